// File: rtl/dvp_source_pkg.sv
// Shared definitions for the DVP transmit path: state encoding and the default
// timing used by both the source and the capture-side benches.
package dvp_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4
  } dvp_state_e;

  localparam int DVP_H_ACTIVE  = 16;
  localparam int DVP_V_ACTIVE  = 12;
  localparam int DVP_VSYNC_LEN = 4;
  localparam int DVP_V_BP      = 10;
  localparam int DVP_H_BLANK   = 10;
  localparam int DVP_CNT_W     = 12;

endpackage

// File: rtl/dvp_source_timing_gen.sv
// DVP frame timing: state machine with cycle, pixel (X) and line (Y) counters.
// Emits the current/next state, byte phase and the pixel-load strobe.
module dvp_timing_gen
  import dvp_source_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int VSYNC_LEN = DVP_VSYNC_LEN,
  parameter int V_BP      = DVP_V_BP,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int CNT_W     = DVP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output dvp_state_e       state_o,
  output dvp_state_e       state_nxt_o,
  output logic             phase_o,
  output logic             load_pixel_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o
);

  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_LEN - 1);
  localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(V_BP - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);

  dvp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
    end
  end

  // ACTIVE is timed by X/phase, so the cycle counter parks at zero there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = ST_VBP;
          cnt_d   = '0;
        end
      end
      ST_VBP: begin
        if (cnt_q == VBP_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          x_d     = '0;
          phase_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        if (phase_q) begin
          x_d = x_q + 1'b1;
          if (x_q == X_LAST) state_d = ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d   = '0;
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q < Y_LAST) begin
            state_d = ST_ACTIVE;
            y_d     = y_q + 1'b1;
          end else begin
            state_d = enable ? ST_VSYNC : ST_IDLE;
            y_d     = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load strobe marks every cycle whose following output byte is a high byte.
  always_comb begin
    load_pixel_o = 1'b0;
    frame_end_o  = 1'b0;
    case (state_q)
      ST_VBP:    load_pixel_o = (cnt_q == VBP_LAST);
      ST_ACTIVE: load_pixel_o = phase_q && (x_q != X_LAST);
      ST_HBLANK: begin
        load_pixel_o = (cnt_q == HB_LAST) && (y_q < Y_LAST);
        frame_end_o  = (cnt_q == HB_LAST) && !(y_q < Y_LAST);
      end
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign state_nxt_o = state_d;
  assign phase_o     = phase_q;
  assign x_o         = x_q;
  assign y_o         = y_q;

endmodule

// File: rtl/dvp_source.sv
// DVP transmit source: serialises 16-bit RGB565 pixels into Vsync/Href/Data,
// high byte first, with a never-stalling ready/valid upstream handshake.
module dvp_source
  import dvp_source_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int VSYNC_LEN = DVP_VSYNC_LEN,
  parameter int V_BP      = DVP_V_BP,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int CNT_W     = DVP_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic             PixelValid,
  input  logic [15:0]      PixelData,
  output logic             PixelReady,
  output logic             Vsync,
  output logic             Href,
  output logic [7:0]       Data,
  output logic [CNT_W-1:0] Xaddr,
  output logic [CNT_W-1:0] Yaddr,
  output logic             FrameDone,
  output logic             Underflow
);

  dvp_state_e       state, state_nxt;
  logic             phase, load_pixel, frame_end;
  logic [CNT_W-1:0] x_cnt, y_cnt;

  logic       vsync_q, vsync_d;
  logic       href_q, href_d;
  logic       frame_done_q, frame_done_d;
  logic       underflow_q, underflow_d;
  logic [7:0] data_q, data_d;
  logic [7:0] lo_q, lo_d;
  logic [15:0] pixel;

  dvp_timing_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .VSYNC_LEN (VSYNC_LEN),
    .V_BP      (V_BP),
    .H_BLANK   (H_BLANK),
    .CNT_W     (CNT_W)
  ) u_timing (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .enable       (Enable),
    .state_o      (state),
    .state_nxt_o  (state_nxt),
    .phase_o      (phase),
    .load_pixel_o (load_pixel),
    .frame_end_o  (frame_end),
    .x_o          (x_cnt),
    .y_o          (y_cnt)
  );

  // A missing upstream pixel is replaced by black; timing never waits.
  always_comb begin
    pixel        = PixelValid ? PixelData : '0;
    vsync_d      = (state_nxt == ST_VSYNC);
    href_d       = (state_nxt == ST_ACTIVE);
    frame_done_d = frame_end;
    underflow_d  = load_pixel && !PixelValid;
    lo_d         = lo_q;
    data_d       = '0;
    if (load_pixel) begin
      data_d = pixel[15:8];
      lo_d   = pixel[7:0];
    end else if (state == ST_ACTIVE && !phase) begin
      data_d = lo_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      data_q       <= '0;
      lo_q         <= '0;
    end else begin
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      data_q       <= data_d;
      lo_q         <= lo_d;
    end
  end

  assign PixelReady = load_pixel;
  assign Vsync      = vsync_q;
  assign Href       = href_q;
  assign Data       = data_q;
  assign Xaddr      = x_cnt;
  assign Yaddr      = y_cnt;
  assign FrameDone  = frame_done_q;
  assign Underflow  = underflow_q;

endmodule

// File: doc/dvp_source.md
Name: dvp_source

Overview:
- Transmit end of the camera DVP interface: serialises a 16-bit RGB565 pixel stream into Vsync/Href/8-bit Data, one byte per clock, high byte first.
- Used as an on-chip sensor emulator and pattern source. Drives DVP_Capture in loopback benches and in the ISP path when no camera is fitted.
- Timing is fully parameterised; frames repeat back-to-back while Enable is high.

Parameters:
- H_ACTIVE, 16, pixels per line (Href high for 2*H_ACTIVE cycles)
- V_ACTIVE, 12, lines per frame
- VSYNC_LEN, 4, cycles Vsync high
- V_BP, 10, cycles from Vsync fall to first Href rise
- H_BLANK, 10, Href-low cycles after every line, including the last
- CNT_W, 12, width of internal counters and Xaddr/Yaddr

Ports:
- Clk  in  1  pixel clock; all logic on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Enable  in  1  level; high = generate frames
- PixelValid  in  1  upstream pixel available
- PixelData  in  16  RGB565 pixel
- PixelReady  out  1  pixel accepted this cycle when PixelValid & PixelReady
- Vsync  out  1  DVP frame sync, active high
- Href  out  1  DVP line valid
- Data  out  8  DVP byte
- Xaddr  out  CNT_W  pixel index of byte on Data
- Yaddr  out  CNT_W  line index of byte on Data
- FrameDone  out  1  one-cycle pulse at end of last H_BLANK
- Underflow  out  1  one-cycle pulse when a pixel slot found PixelValid=0

Behaviour:
- Reset (async assert, sync release): state IDLE; Vsync, Href, PixelReady, FrameDone, Underflow = 0; Data, Xaddr, Yaddr = 0; byte phase = 0.
- All DVP outputs are registered and change only on Clk rising edges.
- States and transitions:
  - IDLE -> VSYNC when Enable=1.
  - VSYNC: Vsync=1 for VSYNC_LEN cycles -> VBP.
  - VBP: V_BP cycles -> ACTIVE.
  - ACTIVE: 2*H_ACTIVE cycles -> HBLANK.
  - HBLANK: H_BLANK cycles. If Yaddr < V_ACTIVE-1 -> ACTIVE (Yaddr+1). Otherwise pulse FrameDone and go to VSYNC if Enable=1, else IDLE.
- Enable is sampled only at frame end. Dropping it mid-frame completes the current frame cleanly.
- Frame period = VSYNC_LEN + V_BP + V_ACTIVE*(2*H_ACTIVE + H_BLANK) cycles; 518 with defaults.
- Byte order in ACTIVE:
  - phase 0 outputs PixelData[15:8]; phase 1 outputs the registered low byte.
  - Xaddr increments after phase 1 and resets to 0 at each line start.
- Handshake:
  - PixelReady is combinational and high exactly in cycles whose next registered output is a high byte: last VBP cycle, last HBLANK cycle of a non-final line, and ACTIVE phase-1 cycles except the line's last pixel.
  - The pixel is captured on that edge.
- Underflow: if PixelValid=0 in a PixelReady cycle, pixel 0x0000 is emitted and Underflow pulses. Timing never stalls.
- Outside ACTIVE, Data = 0 and Href = 0.
- Vsync and Href are never high simultaneously.
- Reset mid-frame: outputs clear immediately. The next frame starts with a full VSYNC and no partial line.

Decomposition:
- Shared header dvp_defs.vh holds:
  - state encodings (IDLE, VSYNC, VBP, ACTIVE, HBLANK)
  - default timing constants, shared with DVP_Capture benches
- One natural sub-module, dvp_timing_gen: state machine plus cycle, X and Y counters. It emits state, phase and "load pixel" strobes.
- dvp_source wraps dvp_timing_gen with the byte serialiser and handshake.

Test Plan:
- Defaults, Enable=1, PixelValid=1, PixelData counting from 0x0000:
  - Vsync high 4 cycles; first Href 10 cycles after Vsync falls.
  - Data = 00,00,00,01,…,00,0F per line.
  - 12 lines of 32 Href cycles with 10-cycle gaps; FrameDone 518 cycles after first Vsync rise.
- Loopback into DVP_Capture: DataPixel sequence equals the sent pixels; Xaddr 0..15 and Yaddr 0..11 agree with the source outputs; 3 consecutive frames match.
- PixelValid forced 0 for pixel 5 of line 2:
  - that pixel emitted as 00,00; exactly one Underflow pulse;
  - line length stays 32 cycles; next pixel is the upstream pixel held since.
- Enable dropped at line 6: frame completes to line 11, FrameDone pulses, then Vsync stays 0 and state is IDLE.
- Rst_n pulsed low mid-line 3:
  - Href, Data, Vsync go 0 asynchronously;
  - after release with Enable=1, a full 4-cycle Vsync precedes line 0.
- H_ACTIVE=1, V_ACTIVE=1, H_BLANK=1: Href high exactly 2 cycles per frame; period = 4+10+3 = 17 cycles; PixelReady once per frame.
